fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter IRQ_VECTOR, default 32'h8000_0004, interrupt handler address.
REQ-002 SHALL have parameter TIMEOUT, default 255, imem wait-cycle limit before timeout flag (8-bit counter).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_pcsrc  in  2  ID redirect request: 00 seq, 01 branch, 10 jump, 11 register.
REQ-006 SHALL have port id_target  in  32  redirect target from ID.
REQ-007 SHALL have port load_use_stall  in  1  hazard-unit stall request.
REQ-008 SHALL have port imem_ready  in  1  instruction fetch completes this cycle.
REQ-009 SHALL have port if_pc  in  32  current PC value.
REQ-010 SHALL have port pc_stall  out  1  hold PC (drives PC stall input).
REQ-011 SHALL have port pc_src  out  2  PC next-source select, same encoding as id_pcsrc.
REQ-012 SHALL have port redirect_addr  out  32  target, wired to all three PC target inputs.
REQ-013 SHALL have port flush_if_id  out  1  squash IF/ID register.
REQ-014 SHALL have port imem_req  out  1  fetch request.
REQ-015 SHALL have port imem_timeout  out  1  sticky timeout flag.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD; IDLE->FETCH unconditionally after one cycle.
REQ-017 SHALL drive in IDLE: pc_stall=1, pc_src=00, flush_if_id=0, imem_req=0.
REQ-018 SHALL drive imem_req=1 in FETCH and HOLD.
REQ-019 SHALL, in FETCH, apply priority: irq (if enabled) > load_use_stall > imem_ready=0 > redirect > sequential.
REQ-020 SHALL, in FETCH with load_use_stall=1: pc_stall=1, pc_src=00, flush_if_id=0, id_pcsrc ignored (ID re-presents it).
REQ-021 SHALL, in FETCH with imem_ready=0, id_pcsrc=00: pc_stall=1, stay FETCH.
REQ-022 SHALL, in FETCH with imem_ready=1, id_pcsrc!=00: pc_stall=0, pc_src=id_pcsrc, redirect_addr=id_target, flush_if_id=1 same cycle (combinational).
REQ-023 SHALL, in FETCH with imem_ready=0, id_pcsrc!=00: latch id_pcsrc/id_target into pending registers, pc_stall=1, flush_if_id=1, next state HOLD.
REQ-024 SHALL, in HOLD with imem_ready=0: pc_stall=1, flush_if_id=0; id_pcsrc and load_use_stall ignored.
REQ-025 SHALL, in HOLD with imem_ready=1: pc_stall=0, pc_src=pending src, redirect_addr=pending target, flush_if_id=1, clear pending, next FETCH.
REQ-026 SHALL drive redirect_addr=0 whenever pc_src=00.
REQ-027 SHALL count consecutive imem_ready=0 cycles with imem_req=1, reset count on imem_ready=1, saturate at TIMEOUT; set imem_timeout when count reaches TIMEOUT, held until reset.

Reset
REQ-028 SHALL, on reset low (asynchronous), force state IDLE, clear pending registers, counter, imem_timeout, and all IRQ state.
REQ-029 SHALL, when reset asserts mid-HOLD, discard the pending redirect; first fetch after release is sequential from PC.

Configuration
REQ-030 SHALL provide macro FETCH_CTRL_IRQ_EN; when defined, add ports irq in 1, eret in 1, epc out 32.
REQ-031 SHALL, with FETCH_CTRL_IRQ_EN, take irq in FETCH when imem_ready=1, load_use_stall=0, mask=0: pc_src=11, redirect_addr=IRQ_VECTOR, flush_if_id=1, set mask, epc<=id_target if id_pcsrc!=00 else if_pc.
REQ-032 SHALL, with FETCH_CTRL_IRQ_EN, defer irq while in HOLD; clear mask on eret=1 (one cycle); epc reset 0.
REQ-033 SHALL, without FETCH_CTRL_IRQ_EN, omit irq/eret/epc ports and all IRQ logic.

Verification
REQ-034 SHALL cover: reset release, imem_ready=1 -> one IDLE cycle with pc_stall=1, then pc_stall=0, pc_src=00.
REQ-035 SHALL cover: id_pcsrc=01, id_target=32'h40, imem_ready=1 -> same cycle pc_src=01, redirect_addr=32'h40, flush_if_id=1.
REQ-036 SHALL cover: id_pcsrc=10, target 32'h100, imem_ready=0 for 3 cycles -> pc_stall=1 throughout, then pc_src=10, redirect_addr=32'h100, flush_if_id=1.
REQ-037 SHALL cover: load_use_stall=1 with id_pcsrc=01 -> pc_stall=1, pc_src=00, flush_if_id=0.
REQ-038 SHALL cover: imem_ready=0 for 255 cycles -> imem_timeout=1 and stays 1 after imem_ready=1; reset clears it.
REQ-039 SHALL cover (IRQ_EN): irq=1, if_pc=32'h20, no redirect -> pc_src=11, redirect_addr=32'h8000_0004, epc=32'h20; second irq ignored until eret.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus: ID redirect/hazard inputs, PC/IMEM control outputs.
// The irq/eret/epc members exist only when FETCH_CTRL_IRQ_EN is defined.
interface fetch_ctrl_if;
   logic [1:0]  id_pcsrc;
   logic [31:0] id_target;
   logic        load_use_stall;
   logic        imem_ready;
   logic [31:0] if_pc;
   logic        pc_stall;
   logic [1:0]  pc_src;
   logic [31:0] redirect_addr;
   logic        flush_if_id;
   logic        imem_req;
   logic        imem_timeout;
   logic [1:0]  dbg_state;
`ifdef FETCH_CTRL_IRQ_EN
   logic        irq;
   logic        eret;
   logic [31:0] epc;

   modport master (
      input  id_pcsrc, id_target, load_use_stall, imem_ready, if_pc, irq, eret,
      output pc_stall, pc_src, redirect_addr, flush_if_id, imem_req, imem_timeout,
             dbg_state, epc
   );
   modport slave (
      output id_pcsrc, id_target, load_use_stall, imem_ready, if_pc, irq, eret,
      input  pc_stall, pc_src, redirect_addr, flush_if_id, imem_req, imem_timeout,
             dbg_state, epc
   );
`else
   modport master (
      input  id_pcsrc, id_target, load_use_stall, imem_ready, if_pc,
      output pc_stall, pc_src, redirect_addr, flush_if_id, imem_req, imem_timeout,
             dbg_state
   );
   modport slave (
      output id_pcsrc, id_target, load_use_stall, imem_ready, if_pc,
      input  pc_stall, pc_src, redirect_addr, flush_if_id, imem_req, imem_timeout,
             dbg_state
   );
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC stall/redirect steering, IMEM request and sticky timeout.
// Optional interrupt entry (vector, mask, epc) enabled by macro FETCH_CTRL_IRQ_EN.
module fetch_ctrl #(
   parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
   parameter int          TIMEOUT    = 255
) (
   input  logic         clk,
   input  logic         reset,
   fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] TMAX = 8'(TIMEOUT);

   state_t      r_state;
   logic [1:0]  r_pend_src;
   logic [31:0] r_pend_tgt;
   logic [7:0]  r_cnt;
   logic        r_timeout;

   logic        w_stall;
   logic [1:0]  w_src;
   logic [31:0] w_addr;
   logic        w_flush;
   logic        w_req;
   logic        w_latch;
   logic        w_irq_take;
   logic        w_cnt_inc;

`ifdef FETCH_CTRL_IRQ_EN
   logic        r_mask;
   logic [31:0] r_epc;

   assign w_irq_take = (r_state == S_FETCH) && bus.irq && bus.imem_ready &&
                       !bus.load_use_stall && !r_mask;
`else
   assign w_irq_take = 1'b0;
`endif

   // Steering is combinational so a redirect and its flush land in the same cycle.
   always_comb begin
      w_stall = 1'b1;
      w_src   = 2'b00;
      w_addr  = 32'h0;
      w_flush = 1'b0;
      w_req   = 1'b0;
      w_latch = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_req = 1'b1;
            if (w_irq_take) begin
               w_stall = 1'b0;
               w_src   = 2'b11;
               w_addr  = IRQ_VECTOR;
               w_flush = 1'b1;
            end else if (bus.load_use_stall) begin
               w_stall = 1'b1;
            end else if (!bus.imem_ready) begin
               w_stall = 1'b1;
               if (bus.id_pcsrc != 2'b00) begin
                  w_flush = 1'b1;
                  w_latch = 1'b1;
               end
            end else if (bus.id_pcsrc != 2'b00) begin
               w_stall = 1'b0;
               w_src   = bus.id_pcsrc;
               w_addr  = bus.id_target;
               w_flush = 1'b1;
            end else begin
               w_stall = 1'b0;
            end
         end
         S_HOLD: begin
            w_req = 1'b1;
            if (bus.imem_ready) begin
               w_stall = 1'b0;
               w_src   = r_pend_src;
               w_addr  = r_pend_tgt;
               w_flush = 1'b1;
            end
         end
         default: begin
            w_stall = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_pend_src <= 2'b00;
         r_pend_tgt <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_FETCH;
            S_FETCH: begin
               if (w_latch) begin
                  r_pend_src <= bus.id_pcsrc;
                  r_pend_tgt <= bus.id_target;
                  r_state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (bus.imem_ready) begin
                  r_pend_src <= 2'b00;
                  r_pend_tgt <= 32'h0;
                  r_state    <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Wait-cycle counter; the flag rises on the edge the count reaches TMAX.
   assign w_cnt_inc = w_req && !bus.imem_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= 8'h0;
         r_timeout <= 1'b0;
      end else begin
         if (bus.imem_ready) begin
            r_cnt <= 8'h0;
         end else if (w_cnt_inc && (r_cnt != TMAX)) begin
            r_cnt <= r_cnt + 8'h1;
            if ((r_cnt + 8'h1) == TMAX) r_timeout <= 1'b1;
         end
      end
   end

`ifdef FETCH_CTRL_IRQ_EN
   // Return address is the redirect target when ID is redirecting, else the current PC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mask <= 1'b0;
         r_epc  <= 32'h0;
      end else if (w_irq_take) begin
         r_mask <= 1'b1;
         r_epc  <= (bus.id_pcsrc != 2'b00) ? bus.id_target : bus.if_pc;
      end else if (bus.eret) begin
         r_mask <= 1'b0;
      end
   end

   assign bus.epc = r_epc;
`endif

   assign bus.pc_stall      = w_stall;
   assign bus.pc_src        = w_src;
   assign bus.redirect_addr = (w_src == 2'b00) ? 32'h0 : w_addr;
   assign bus.flush_if_id   = w_flush;
   assign bus.imem_req      = w_req;
   assign bus.imem_timeout  = r_timeout;
   assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed steps push expected outputs,
// a negedge monitor pops and compares. IRQ cases run when FETCH_CTRL_IRQ_EN is set.
module tb_fetch_ctrl;

   localparam logic [31:0] IRQV = 32'h8000_0004;

   logic clk;
   logic reset;

   fetch_ctrl_if bus ();

   fetch_ctrl #(.IRQ_VECTOR(IRQV), .TIMEOUT(255)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector: {pc_stall, pc_src, redirect_addr, flush_if_id, imem_req, imem_timeout, epc}
   logic [69:0] exp_q[$];
   string       name_q[$];
   int          n_err = 0;
   int          n_chk = 0;
   logic        exp_to = 1'b0;
   logic [31:0] exp_epc = 32'h0;
   logic        t_irq = 1'b0;
   logic        t_eret = 1'b0;
   logic [31:0] t_if_pc = 32'h0;

   task automatic push(input string nm, input logic st, input logic [1:0] src,
                       input logic [31:0] addr, input logic fl, input logic req);
      exp_q.push_back({st, src, addr, fl, req, exp_to, exp_epc});
      name_q.push_back(nm);
   endtask

   task automatic drive(input logic [1:0] pcsrc, input logic [31:0] tgt,
                        input logic lus, input logic rdy);
      bus.id_pcsrc       = pcsrc;
      bus.id_target      = tgt;
      bus.load_use_stall = lus;
      bus.imem_ready     = rdy;
      bus.if_pc          = t_if_pc;
`ifdef FETCH_CTRL_IRQ_EN
      bus.irq            = t_irq;
      bus.eret           = t_eret;
`endif
   endtask

   task automatic step(input string nm, input logic [1:0] pcsrc, input logic [31:0] tgt,
                       input logic lus, input logic rdy, input logic st,
                       input logic [1:0] src, input logic [31:0] addr, input logic fl);
      @(posedge clk);
      #1;
      drive(pcsrc, tgt, lus, rdy);
      push(nm, st, src, addr, fl, 1'b1);
   endtask

   // Asserts reset mid-cycle (async), then releases it one edge later.
   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(2'b00, 32'h0, 1'b0, 1'b1);
      exp_to  = 1'b0;
      exp_epc = 32'h0;
      push("in_reset", 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      push("idle_after_release", 1'b1, 2'b00, 32'h0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      logic [69:0] e;
      logic [69:0] got;
      string       nm;
      if (exp_q.size() != 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
`ifdef FETCH_CTRL_IRQ_EN
         got = {bus.pc_stall, bus.pc_src, bus.redirect_addr, bus.flush_if_id,
                bus.imem_req, bus.imem_timeout, bus.epc};
`else
         got = {bus.pc_stall, bus.pc_src, bus.redirect_addr, bus.flush_if_id,
                bus.imem_req, bus.imem_timeout, 32'h0};
`endif
         n_chk++;
         if (got !== e) begin
            n_err++;
            $display("FAIL %s: got stall=%b src=%b addr=%h flush=%b req=%b to=%b epc=%h, exp stall=%b src=%b addr=%h flush=%b req=%b to=%b epc=%h",
                     nm, got[69], got[68:67], got[66:35], got[34], got[33], got[32], got[31:0],
                     e[69], e[68:67], e[66:35], e[34], e[33], e[32], e[31:0]);
         end
      end
   end

   initial begin
      reset = 1'b0;
      drive(2'b00, 32'h0, 1'b0, 1'b1);

      do_reset();
      step("seq_first",     2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
      step("branch_ready",  2'b01, 32'h40,  1'b0, 1'b1, 1'b0, 2'b01, 32'h40,  1'b1);
      step("jump_latch",    2'b10, 32'h100, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0,   1'b1);
      step("hold_wait1",    2'b00, 32'h999, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0,   1'b0);
      step("hold_wait2",    2'b01, 32'h555, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0,   1'b0);
      step("hold_release",  2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b10, 32'h100, 1'b1);
      step("seq_after_hold",2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
      step("lus_branch",    2'b01, 32'h40,  1'b1, 1'b1, 1'b1, 2'b00, 32'h0,   1'b0);
      step("lus_not_ready", 2'b10, 32'h200, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0,   1'b0);
      step("no_hold_by_lus",2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
      step("reg_redirect",  2'b11, 32'h1234,1'b0, 1'b1, 1'b0, 2'b11, 32'h1234,1'b1);

`ifdef FETCH_CTRL_IRQ_EN
      t_irq = 1'b1; t_if_pc = 32'h20;
      step("irq_take",      2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b11, IRQV,    1'b1);
      exp_epc = 32'h20;
      step("irq_masked",    2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
      t_irq = 1'b0; t_eret = 1'b1;
      step("eret",          2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
      t_eret = 1'b0; t_irq = 1'b1; t_if_pc = 32'h44;
      step("irq_on_redir",  2'b01, 32'h90,  1'b0, 1'b1, 1'b0, 2'b11, IRQV,    1'b1);
      t_irq = 1'b0;
      exp_epc = 32'h90;
      step("epc_is_target", 2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
`endif

      for (int k = 1; k <= 255; k++) begin
         step($sformatf("wait_%0d", k), 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0);
      end
      exp_to = 1'b1;
      step("timeout_set",   2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
      step("timeout_sticky",2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);

      do_reset();
      step("post_reset_seq",2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
      step("hold_enter",    2'b01, 32'h77,  1'b0, 1'b0, 1'b1, 2'b00, 32'h0,   1'b1);
      step("hold_mid",      2'b00, 32'h0,   1'b0, 1'b0, 1'b1, 2'b00, 32'h0,   1'b0);
      do_reset();
      step("seq_not_pend",  2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);
      step("seq_again",     2'b00, 32'h0,   1'b0, 1'b1, 1'b0, 2'b00, 32'h0,   1'b0);

      @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending checks, exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
